// File: rtl/fpu_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpu_bist_ctrl
// Description : On-chip stimulus/check engine for the combinational bfloat16
//               fpu. Walks a synchronous-read vector ROM, presents each
//               operand pair to the fpu, registers the fpu result and compares
//               it bit-exactly against the golden value from the ROM.
//               Accumulates saturating mismatch/overflow counts, captures the
//               first mismatch and reports pass/fail when the run completes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock / synchronous active-high reset
//   start_i, op_sel_i   run request and operation select (0001 ADD, else MUL)
//   vec_rd_o/addr_o     vector ROM read strobe and address
//   vec_a_i/b_i         ROM operands (valid the cycle after vec_rd_o)
//   add_gold_i/mul_*    ROM golden results (same timing)
//   fpu_op_o/in1/in2    stimulus to the fpu
//   fpu_out_i/ovf_i     fpu result and overflow flag
//   busy_o/done_o/pass_o run status
//   err_cnt_o/ovf_cnt_o saturating statistics for the current run
//   first_err_*         index and fpu result of the first mismatching vector
// ============================================================================
module fpu_bist_ctrl #(
  parameter int NUM_VEC = 10,
  parameter int ADDR_W  = 4,
  parameter int ERR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [3:0]        op_sel_i,
  output logic              vec_rd_o,
  output logic [ADDR_W-1:0] vec_addr_o,
  input  logic [15:0]       vec_a_i,
  input  logic [15:0]       vec_b_i,
  input  logic [15:0]       add_gold_i,
  input  logic [15:0]       mul_gold_i,
  output logic [3:0]        fpu_op_o,
  output logic [15:0]       fpu_in1_o,
  output logic [15:0]       fpu_in2_o,
  input  logic [15:0]       fpu_out_i,
  input  logic              fpu_overflow_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ERR_W-1:0]  ovf_cnt_o,
  output logic              first_err_vld_o,
  output logic [ADDR_W-1:0] first_err_idx_o,
  output logic [15:0]       first_err_out_o
);

  localparam logic [3:0]        c_OP_ADD   = 4'b0001;
  localparam logic [3:0]        c_OP_MUL   = 4'b0100;
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0]  c_CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRIVE   = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_op_add;     // latched operation for the whole run
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_gold;
  logic [15:0]       r_fpu_out;
  logic              r_fpu_ovf;

  logic              r_vec_rd;
  logic [ADDR_W-1:0] r_vec_addr;
  logic [3:0]        r_fpu_op;
  logic [15:0]       r_fpu_in1;
  logic [15:0]       r_fpu_in2;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ERR_W-1:0]  r_ovf_cnt;
  logic              r_first_vld;
  logic [ADDR_W-1:0] r_first_idx;
  logic [15:0]       r_first_out;

  logic              w_mismatch;
  logic              w_last;
  logic              w_is_add;
  logic [ERR_W-1:0]  w_err_next;
  logic [ERR_W-1:0]  w_ovf_next;

  // Exact 16-bit compare: no NaN or signed-zero equivalence.
  assign w_mismatch = (r_fpu_out != r_gold);
  assign w_last     = (r_idx == c_LAST_IDX);
  assign w_is_add   = (op_sel_i == c_OP_ADD);

  // Saturating increments: the counters stick at all-ones.
  assign w_err_next = (w_mismatch && (r_err_cnt != c_CNT_MAX)) ? r_err_cnt + 1'b1 : r_err_cnt;
  assign w_ovf_next = (r_fpu_ovf && (r_ovf_cnt != c_CNT_MAX)) ? r_ovf_cnt + 1'b1 : r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_add    <= 1'b0;
      r_idx       <= '0;
      r_gold      <= '0;
      r_fpu_out   <= '0;
      r_fpu_ovf   <= 1'b0;
      r_vec_rd    <= 1'b0;
      r_vec_addr  <= '0;
      r_fpu_op    <= 4'b0000;
      r_fpu_in1   <= '0;
      r_fpu_in2   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_ovf_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      r_first_out <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_op_add    <= w_is_add;
            r_fpu_op    <= w_is_add ? c_OP_ADD : c_OP_MUL;
            r_idx       <= '0;
            r_vec_rd    <= 1'b1;
            r_vec_addr  <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_ovf_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_first_out <= '0;
            r_state     <= S_FETCH;
          end
        end

        // Read strobe was raised on entry; drop it so it lasts one cycle.
        S_FETCH: begin
          r_vec_rd <= 1'b0;
          r_state  <= S_CAPTURE;
        end

        // ROM data is valid now; operands go straight into the fpu drivers
        // so they are stable for the rest of this vector.
        S_CAPTURE: begin
          r_fpu_in1 <= vec_a_i;
          r_fpu_in2 <= vec_b_i;
          r_gold    <= r_op_add ? add_gold_i : mul_gold_i;
          r_state   <= S_DRIVE;
        end

        S_DRIVE: begin
          r_fpu_out <= fpu_out_i;
          r_fpu_ovf <= fpu_overflow_i;
          r_state   <= S_CHECK;
        end

        S_CHECK: begin
          r_err_cnt <= w_err_next;
          r_ovf_cnt <= w_ovf_next;
          if (w_mismatch && !r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_idx <= r_idx;
            r_first_out <= r_fpu_out;
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_state <= S_DONE;
          end else begin
            r_idx      <= r_idx + 1'b1;
            r_vec_rd   <= 1'b1;
            r_vec_addr <= r_idx + 1'b1;
            r_state    <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vec_rd_o        = r_vec_rd;
  assign vec_addr_o      = r_vec_addr;
  assign fpu_op_o        = r_fpu_op;
  assign fpu_in1_o       = r_fpu_in1;
  assign fpu_in2_o       = r_fpu_in2;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign err_cnt_o       = r_err_cnt;
  assign ovf_cnt_o       = r_ovf_cnt;
  assign first_err_vld_o = r_first_vld;
  assign first_err_idx_o = r_first_idx;
  assign first_err_out_o = r_first_out;

endmodule
`default_nettype wire

// File: tb/tb_fpu_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_bist_ctrl
// Description : Self-checking bench for fpu_bist_ctrl. Provides a vector ROM
//               and a table-lookup fpu model; runs a table of scenarios plus
//               hand-written reset, mid-run start and saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_sel = 4'b0000;

  logic        vec_rd;
  logic [3:0]  vec_addr;
  logic [15:0] vec_a, vec_b, add_gold, mul_gold;
  logic [3:0]  fpu_op;
  logic [15:0] fpu_in1, fpu_in2;
  logic [15:0] fpu_out;
  logic        fpu_ovf;
  logic        busy, done, pass;
  logic [15:0] err_cnt, ovf_cnt;
  logic        fvld;
  logic [3:0]  fidx;
  logic [15:0] fout;

  // Second instance: 5 vectors, 2-bit counters, fpu result always wrong.
  logic        s_start = 1'b0;
  logic        s_vec_rd;
  logic [3:0]  s_vec_addr;
  logic [15:0] s_a, s_b, s_addg, s_mulg;
  logic [3:0]  s_fop;
  logic [15:0] s_in1, s_in2;
  logic        s_busy, s_done, s_pass;
  logic [1:0]  s_err, s_ovf;
  logic        s_fvld;
  logic [3:0]  s_fidx;
  logic [15:0] s_fout;

  // Vector table: operands, true results and overflow (MUL only).
  logic [15:0] t_a [16];
  logic [15:0] t_b [16];
  logic [15:0] t_add [16];
  logic [15:0] t_mul [16];
  logic        t_ovf [16];
  logic [15:0] cur_add_mask = 16'h0000;
  logic [15:0] cur_mul_mask = 16'h0000;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  fpu_bist_ctrl #(.NUM_VEC(10), .ADDR_W(4), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .op_sel_i(op_sel),
    .vec_rd_o(vec_rd), .vec_addr_o(vec_addr),
    .vec_a_i(vec_a), .vec_b_i(vec_b), .add_gold_i(add_gold), .mul_gold_i(mul_gold),
    .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2),
    .fpu_out_i(fpu_out), .fpu_overflow_i(fpu_ovf),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_cnt_o(err_cnt), .ovf_cnt_o(ovf_cnt),
    .first_err_vld_o(fvld), .first_err_idx_o(fidx), .first_err_out_o(fout)
  );

  fpu_bist_ctrl #(.NUM_VEC(5), .ADDR_W(4), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start_i(s_start), .op_sel_i(4'b0100),
    .vec_rd_o(s_vec_rd), .vec_addr_o(s_vec_addr),
    .vec_a_i(s_a), .vec_b_i(s_b), .add_gold_i(s_addg), .mul_gold_i(s_mulg),
    .fpu_op_o(s_fop), .fpu_in1_o(s_in1), .fpu_in2_o(s_in2),
    .fpu_out_i(16'hFFFF), .fpu_overflow_i(1'b0),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass),
    .err_cnt_o(s_err), .ovf_cnt_o(s_ovf),
    .first_err_vld_o(s_fvld), .first_err_idx_o(s_fidx), .first_err_out_o(s_fout)
  );

  // Sync-read ROMs; golden values optionally corrupted by flipping bit 6.
  always @(posedge clk) begin
    if (vec_rd) begin
      vec_a    <= t_a[vec_addr];
      vec_b    <= t_b[vec_addr];
      add_gold <= t_add[vec_addr] ^ (cur_add_mask[vec_addr] ? 16'h0040 : 16'h0000);
      mul_gold <= t_mul[vec_addr] ^ (cur_mul_mask[vec_addr] ? 16'h0040 : 16'h0000);
    end
    if (s_vec_rd) begin
      s_a    <= t_a[s_vec_addr];
      s_b    <= t_b[s_vec_addr];
      s_addg <= t_add[s_vec_addr];
      s_mulg <= t_mul[s_vec_addr];
    end
  end

  // fpu model: look the operand pair up in the table.
  always_comb begin
    fpu_out = 16'h0000;
    fpu_ovf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (t_a[i] == fpu_in1 && t_b[i] == fpu_in2) begin
        fpu_out = (fpu_op == 4'b0001) ? t_add[i] : t_mul[i];
        fpu_ovf = (fpu_op != 4'b0001) && t_ovf[i];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [3:0]  op_sel;
    logic [15:0] add_mask;
    logic [15:0] mul_mask;
    int          mid_start;
    logic [15:0] exp_err;
    logic [15:0] exp_ovf;
    logic        exp_pass;
    logic        exp_vld;
    logic [3:0]  exp_idx;
    logic [15:0] exp_out;
    logic [3:0]  exp_op;
  } vec_t;

  vec_t tv [6];

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"},  32'(err_cnt), 32'd0);
    chk({tag, "_ovf"},  32'(ovf_cnt), 32'd0);
    chk({tag, "_fvld"}, 32'(fvld), 32'd0);
    chk({tag, "_fidx"}, 32'(fidx), 32'd0);
    chk({tag, "_fout"}, 32'(fout), 32'd0);
    chk({tag, "_fop"},  32'(fpu_op), 32'd0);
    chk({tag, "_in1"},  32'(fpu_in1), 32'd0);
    chk({tag, "_in2"},  32'(fpu_in2), 32'd0);
    chk({tag, "_rd"},   32'(vec_rd), 32'd0);
    chk({tag, "_addr"}, 32'(vec_addr), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int nrd;
    cur_add_mask = v.add_mask;
    cur_mul_mask = v.mul_mask;
    @(negedge clk);
    start  = 1'b1;
    op_sel = v.op_sel;
    @(negedge clk);
    start  = 1'b0;
    op_sel = 4'b1000;
    cyc = 0;
    nrd = 0;
    chk({tag, "_clr_err"},  32'(err_cnt), 32'd0);
    chk({tag, "_clr_fvld"}, 32'(fvld), 32'd0);
    chk({tag, "_clr_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd1);
    while (!done && cyc < 200) begin
      chk({tag, "_rd"}, 32'(vec_rd), 32'((cyc % 4) == 0));
      if (vec_rd) begin
        chk({tag, "_addr"}, 32'(vec_addr), 32'(nrd));
        nrd++;
      end
      chk({tag, "_fop"}, 32'(fpu_op), 32'(v.exp_op));
      start  = (cyc == v.mid_start);
      op_sel = (cyc == v.mid_start) ? 4'b0001 : 4'b1000;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'd40);
    chk({tag, "_nrd"},     32'(nrd), 32'd10);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd1);
    chk({tag, "_pass"},    32'(pass), 32'(v.exp_pass));
    chk({tag, "_err"},     32'(err_cnt), 32'(v.exp_err));
    chk({tag, "_ovf"},     32'(ovf_cnt), 32'(v.exp_ovf));
    chk({tag, "_fvld"},    32'(fvld), 32'(v.exp_vld));
    chk({tag, "_fidx"},    32'(fidx), 32'(v.exp_idx));
    chk({tag, "_fout"},    32'(fout), 32'(v.exp_out));
    chk({tag, "_fop_end"}, 32'(fpu_op), 32'(v.exp_op));
    chk({tag, "_in1_hold"}, 32'(fpu_in1), 32'(t_a[9]));
    chk({tag, "_in2_hold"}, 32'(fpu_in2), 32'(t_b[9]));
    chk({tag, "_addr_hold"}, 32'(vec_addr), 32'd9);
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, 32'(done), 32'd1);
  endtask

  task automatic run_sat(input string tag);
    int cyc;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 0;
    chk({tag, "_clr_err"}, 32'(s_err), 32'd0);
    while (!s_done && cyc < 100) begin
      if (cyc == 8)  chk({tag, "_err_c8"},  32'(s_err), 32'd2);
      if (cyc == 16) chk({tag, "_err_c16"}, 32'(s_err), 32'd3);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd20);
    chk({tag, "_err"},  32'(s_err), 32'd3);
    chk({tag, "_ovf"},  32'(s_ovf), 32'd0);
    chk({tag, "_pass"}, 32'(s_pass), 32'd0);
    chk({tag, "_fvld"}, 32'(s_fvld), 32'd1);
    chk({tag, "_fidx"}, 32'(s_fidx), 32'd0);
    chk({tag, "_fout"}, 32'(s_fout), 32'hFFFF);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      t_a[i] = 16'hFFFF; t_b[i] = 16'hFFFF; t_add[i] = 16'h0000; t_mul[i] = 16'h0000; t_ovf[i] = 1'b0;
    end
    //          a              b              a+b              a*b
    t_a[0] = 16'h3F80; t_b[0] = 16'h4000; t_add[0] = 16'h4040; t_mul[0] = 16'h4000;
    t_a[1] = 16'h4000; t_b[1] = 16'h4000; t_add[1] = 16'h4080; t_mul[1] = 16'h4080;
    t_a[2] = 16'h4040; t_b[2] = 16'h4000; t_add[2] = 16'h40A0; t_mul[2] = 16'h40C0;
    t_a[3] = 16'h3F80; t_b[3] = 16'h3F80; t_add[3] = 16'h4000; t_mul[3] = 16'h3F80;
    t_a[4] = 16'h4080; t_b[4] = 16'h3F80; t_add[4] = 16'h40A0; t_mul[4] = 16'h4080;
    t_a[5] = 16'h40A0; t_b[5] = 16'h4000; t_add[5] = 16'h40E0; t_mul[5] = 16'h4120;
    t_a[6] = 16'hBF80; t_b[6] = 16'h3F80; t_add[6] = 16'h0000; t_mul[6] = 16'hBF80;
    t_a[7] = 16'h7F7F; t_b[7] = 16'h4000; t_add[7] = 16'h7F7F; t_mul[7] = 16'h7F80; t_ovf[7] = 1'b1;
    t_a[8] = 16'h4100; t_b[8] = 16'h4000; t_add[8] = 16'h4120; t_mul[8] = 16'h4180;
    t_a[9] = 16'h3F00; t_b[9] = 16'h4000; t_add[9] = 16'h4020; t_mul[9] = 16'h3F80;

    //        op       add_mask  mul_mask  mid  err    ovf    pass  vld   idx   out       op
    tv[0] = '{4'b0100, 16'h0000, 16'h0000, -1, 16'd0, 16'd1, 1'b1, 1'b0, 4'd0, 16'h0000, 4'b0100};
    tv[1] = '{4'b0001, 16'h0008, 16'h0000, -1, 16'd1, 16'd0, 1'b0, 1'b1, 4'd3, 16'h4000, 4'b0001};
    tv[2] = '{4'b0010, 16'h0008, 16'h0020, -1, 16'd1, 16'd1, 1'b0, 1'b1, 4'd5, 16'h4120, 4'b0100};
    tv[3] = '{4'b1111, 16'h0000, 16'h0201, -1, 16'd2, 16'd1, 1'b0, 1'b1, 4'd0, 16'h4000, 4'b0100};
    tv[4] = '{4'b0001, 16'h0200, 16'h0000, -1, 16'd1, 16'd0, 1'b0, 1'b1, 4'd9, 16'h4020, 4'b0001};
    tv[5] = '{4'b0100, 16'h0000, 16'h0000, 13, 16'd0, 16'd1, 1'b1, 1'b0, 4'd0, 16'h0000, 4'b0100};

    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("reset_sat_busy", 32'(s_busy), 32'd0);
    chk("reset_sat_err",  32'(s_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle");

    for (int k = 0; k < 6; k++) begin
      run_vec(tv[k], $sformatf("tv%0d", k));
    end

    // Reset during the DRIVE cycle of vector 5, with one error already counted.
    begin
      int cyc;
      cur_add_mask = 16'h0002;
      cur_mul_mask = 16'h0000;
      @(negedge clk);
      start  = 1'b1;
      op_sel = 4'b0001;
      @(negedge clk);
      start  = 1'b0;
      cyc = 0;
      while (cyc < 22) begin
        @(negedge clk);
        cyc++;
      end
      chk("rstmid_busy_pre", 32'(busy), 32'd1);
      chk("rstmid_err_pre",  32'(err_cnt), 32'd1);
      chk("rstmid_addr_pre", 32'(vec_addr), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero("rstmid");
      repeat (4) @(negedge clk);
      check_zero("rstmid_idle");
    end
    run_vec(tv[0], "after_rst");

    run_sat("sat1");
    run_sat("sat2");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
